// File: rtl/multicycle_control_if.sv
// Control bus between the multi-cycle main control unit and the shared datapath.
// master: the control unit (consumes opcode/flags, drives control lines).
// slave:  the datapath/memory side.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       zero;
    logic       gtz;
    logic       vflag;
    logic       mem_ready;

    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic [3:0] state;
    logic       illegal;
    logic       instr_done;

    modport master (
        input  opcode, zero, gtz, vflag, mem_ready,
        output pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_source, state,
               illegal, instr_done
    );

    modport slave (
        output opcode, zero, gtz, vflag, mem_ready,
        input  pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_source, state,
               illegal, instr_done
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle main control unit for the MIPS-subset CPU.
//
//  state      | meaning
//  -----------+----------------------------------------------------------
//  FETCH  (0) | read instruction at PC, PC <= PC+4 when memory completes
//  DECODE (1) | branch target into ALUOut, dispatch on opcode / flag illegal
//  MEMADR (2) | effective address A + signext imm
//  MEMRD  (3) | load read from ALUOut address, waits on mem_ready
//  MEMWB  (4) | write MDR into rt
//  MEMWR  (5) | store to ALUOut address, waits on mem_ready
//  EXEC   (6) | R-type ALU operation
//  RWB    (7) | write ALUOut into rd
//  BEQ    (8) | compare A-B, take ALUOut target on zero
//  BGTZAL (9) | on rs>0: take target and link PC+4 into $31
//  BRNV  (10) | take target when the last R-type did not overflow
//  11..15     | unreachable, recover to FETCH
module multicycle_control #(
    parameter logic MEM_WAIT  = 1'b1,
    parameter logic EN_BGTZAL = 1'b1,
    parameter logic EN_BRNV   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_control_if.master  bus
);

    localparam logic [5:0] OP_R      = 6'b000000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BGTZAL = 6'b100001;
    localparam logic [5:0] OP_BRNV   = 6'b010100;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_BGTZAL = 4'd9,
        S_BRNV   = 4'd10
    } state_t;

    state_t state_q;
    state_t state_d;

    logic       rdy;
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
    logic       instr_done;

    // Without wait-state support every memory access completes in one cycle.
    assign rdy = MEM_WAIT ? bus.mem_ready : 1'b1;

    // State register with synchronous reset to FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore control decode; reset blanks every output.
    always_comb begin
        state_d    = S_FETCH;
        pc_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_source  = 2'b00;
        illegal    = 1'b0;
        instr_done = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = rdy;
                pc_write  = rdy;
                state_d   = rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                if (bus.opcode == OP_LW || bus.opcode == OP_SW) begin
                    state_d = S_MEMADR;
                end else if (bus.opcode == OP_R) begin
                    state_d = S_EXEC;
                end else if (bus.opcode == OP_BEQ) begin
                    state_d = S_BEQ;
                end else if (EN_BGTZAL && bus.opcode == OP_BGTZAL) begin
                    state_d = S_BGTZAL;
                end else if (EN_BRNV && bus.opcode == OP_BRNV) begin
                    state_d = S_BRNV;
                end else begin
                    illegal    = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                state_d  = rdy ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                mem_to_reg = 2'b01;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = rdy;
                state_d    = rdy ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_RWB;
            end
            S_RWB: begin
                reg_dst    = 2'b01;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_source  = 2'b01;
                pc_write   = bus.zero;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BGTZAL: begin
                // Link value is the PC already advanced to PC+4 during FETCH.
                pc_source  = 2'b01;
                pc_write   = bus.gtz;
                reg_write  = bus.gtz;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRNV: begin
                pc_source  = 2'b01;
                pc_write   = ~bus.vflag;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (reset) begin
            pc_write   = 1'b0;
            iord       = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_dst    = 2'b00;
            mem_to_reg = 2'b00;
            reg_write  = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            pc_source  = 2'b00;
            illegal    = 1'b0;
            instr_done = 1'b0;
        end
    end

    assign bus.pc_write   = pc_write;
    assign bus.iord       = iord;
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.ir_write   = ir_write;
    assign bus.reg_dst    = reg_dst;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.reg_write  = reg_write;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.alu_op     = alu_op;
    assign bus.pc_source  = pc_source;
    assign bus.illegal    = illegal;
    assign bus.instr_done = instr_done;
    assign bus.state      = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: u_a uses default parameters, u_b has no wait
// states and both optional branches disabled. Only one unit runs at a time;
// the other is held in reset.
module tb_multicycle_control;

    localparam logic [5:0] OP_R      = 6'b000000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BGTZAL = 6'b100001;
    localparam logic [5:0] OP_BRNV   = 6'b010100;

    logic       clk = 1'b0;
    logic       rst_a;
    logic       rst_b;
    logic [5:0] opcode;
    logic       zero;
    logic       gtz;
    logic       vflag;
    logic       mem_ready;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    multicycle_control_if ifa ();
    multicycle_control_if ifb ();

    assign ifa.opcode    = opcode;
    assign ifa.zero      = zero;
    assign ifa.gtz       = gtz;
    assign ifa.vflag     = vflag;
    assign ifa.mem_ready = mem_ready;
    assign ifb.opcode    = opcode;
    assign ifb.zero      = zero;
    assign ifb.gtz       = gtz;
    assign ifb.vflag     = vflag;
    assign ifb.mem_ready = mem_ready;

    multicycle_control u_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (ifa.master)
    );

    multicycle_control #(
        .MEM_WAIT  (1'b0),
        .EN_BGTZAL (1'b0),
        .EN_BRNV   (1'b0)
    ) u_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (ifb.master)
    );

    wire [18:0] obs_a = {ifa.pc_write, ifa.iord, ifa.mem_read, ifa.mem_write, ifa.ir_write,
                         ifa.reg_dst, ifa.mem_to_reg, ifa.reg_write, ifa.alu_src_a,
                         ifa.alu_src_b, ifa.alu_op, ifa.pc_source, ifa.illegal, ifa.instr_done};
    wire [18:0] obs_b = {ifb.pc_write, ifb.iord, ifb.mem_read, ifb.mem_write, ifb.ir_write,
                         ifb.reg_dst, ifb.mem_to_reg, ifb.reg_write, ifb.alu_src_a,
                         ifb.alu_src_b, ifb.alu_op, ifb.pc_source, ifb.illegal, ifb.instr_done};

    typedef struct {
        int st;
        bit rdy;
    } cyc_t;

    cyc_t q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, expv);
        end else begin
            n_pass++;
        end
    endtask

    // Control lines the specification lists for each state, packed in obs_* order.
    function automatic logic [18:0] exp_out(input int st, input bit rdy, input bit mw,
                                            input bit bad, input bit z, input bit g, input bit v);
        bit pcw = 0, iord = 0, mr = 0, mwr = 0, irw = 0, rw = 0, asa = 0, ill = 0, done = 0;
        bit [1:0] rd = 0, m2r = 0, asb = 0, aop = 0, pcs = 0;
        bit r;
        r = mw ? rdy : 1'b1;
        case (st)
            0:  begin mr = 1; asb = 2'b01; irw = r; pcw = r; end
            1:  begin asb = 2'b11; ill = bad; done = bad; end
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; iord = 1; end
            4:  begin m2r = 2'b01; rw = 1; done = 1; end
            5:  begin mwr = 1; iord = 1; done = r; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rd = 2'b01; rw = 1; done = 1; end
            8:  begin asa = 1; aop = 2'b01; pcs = 2'b01; pcw = z; done = 1; end
            9:  begin pcs = 2'b01; pcw = g; rw = g; rd = 2'b10; m2r = 2'b10; done = 1; end
            10: begin pcs = 2'b01; pcw = !v; done = 1; end
            default: ;
        endcase
        return {pcw, iord, mr, mwr, irw, rd, m2r, rw, asa, asb, aop, pcs, ill, done};
    endfunction

    // A memory state lasts one cycle plus one per not-ready cycle when waits are honoured.
    function automatic void push_mem(input int st, input int w, input bit mw);
        cyc_t c;
        c.st = st;
        if (mw) begin
            for (int k = 0; k < w; k++) begin
                c.rdy = 1'b0;
                q.push_back(c);
            end
            c.rdy = 1'b1;
        end else begin
            c.rdy = 1'($urandom_range(0, 1));
        end
        q.push_back(c);
    endfunction

    function automatic void push_st(input int st);
        cyc_t c;
        c.st  = st;
        c.rdy = 1'($urandom_range(0, 1));
        q.push_back(c);
    endfunction

    // Runs one instruction on unit sel (0 = u_a, 1 = u_b). With do_abort, reset is
    // pulsed during the first memory wait cycle and the unit must restart at FETCH.
    task automatic run_instr(input bit sel, input logic [5:0] op, input int wf, input int wm,
                             input bit do_abort);
        bit mw, eg, eb, bad, z, g, v, aborted;
        int abort_at;
        logic [18:0] obs;
        logic [3:0]  st_obs;
        mw = !sel;
        eg = !sel;
        eb = !sel;
        bad = !(op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ ||
                (eg && op == OP_BGTZAL) || (eb && op == OP_BRNV));
        q.delete();
        push_mem(0, wf, mw);
        push_st(1);
        if (op == OP_LW) begin
            push_st(2); push_mem(3, wm, mw); push_st(4);
        end else if (op == OP_SW) begin
            push_st(2); push_mem(5, wm, mw);
        end else if (op == OP_R) begin
            push_st(6); push_st(7);
        end else if (op == OP_BEQ) begin
            push_st(8);
        end else if (!bad && op == OP_BGTZAL) begin
            push_st(9);
        end else if (!bad && op == OP_BRNV) begin
            push_st(10);
        end
        abort_at = -1;
        if (do_abort) begin
            for (int k = 0; k < q.size(); k++) begin
                if (abort_at < 0 && (q[k].st == 3 || q[k].st == 5) && !q[k].rdy) abort_at = k;
            end
        end
        aborted = 1'b0;
        for (int i = 0; i < q.size() && !aborted; i++) begin
            z = 1'($urandom_range(0, 1));
            g = 1'($urandom_range(0, 1));
            v = 1'($urandom_range(0, 1));
            opcode    = op;
            mem_ready = q[i].rdy;
            zero      = z;
            gtz       = g;
            vflag     = v;
            if (i == abort_at) begin
                if (sel) rst_b = 1'b1; else rst_a = 1'b1;
            end
            @(negedge clk);
            obs    = sel ? obs_b : obs_a;
            st_obs = sel ? ifb.state : ifa.state;
            if (i == abort_at) begin
                chk("reset outputs", 32'(obs), 32'd0);
                chk("reset state", 32'(st_obs), 32'd0);
                @(posedge clk);
                #1;
                if (sel) rst_b = 1'b0; else rst_a = 1'b0;
                mem_ready = 1'b0;
                @(negedge clk);
                obs    = sel ? obs_b : obs_a;
                st_obs = sel ? ifb.state : ifa.state;
                chk("post-reset state", 32'(st_obs), 32'd0);
                chk("post-reset outputs", 32'(obs), 32'(exp_out(0, 1'b0, mw, 1'b0, z, g, v)));
                aborted = 1'b1;
            end else begin
                chk("state", 32'(st_obs), 32'(q[i].st));
                chk("outputs", 32'(obs), 32'(exp_out(q[i].st, q[i].rdy, mw, bad, z, g, v)));
            end
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [5:0] pick_op();
        case ($urandom_range(0, 6))
            0: return OP_R;
            1: return OP_LW;
            2: return OP_SW;
            3: return OP_BEQ;
            4: return OP_BGTZAL;
            5: return OP_BRNV;
            default: return 6'($urandom_range(0, 63));
        endcase
    endfunction

    initial begin
        rst_a     = 1'b1;
        rst_b     = 1'b1;
        opcode    = OP_LW;
        zero      = 1'b0;
        gtz       = 1'b0;
        vflag     = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            opcode    = 6'($urandom_range(0, 63));
            mem_ready = 1'($urandom_range(0, 1));
            zero      = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("reset outputs a", 32'(obs_a), 32'd0);
            chk("reset state a", 32'(ifa.state), 32'd0);
            chk("reset outputs b", 32'(obs_b), 32'd0);
            @(posedge clk);
            #1;
        end
        rst_a = 1'b0;

        run_instr(1'b0, OP_LW, 0, 0, 1'b0);
        run_instr(1'b0, OP_LW, 0, 2, 1'b0);
        run_instr(1'b0, OP_SW, 1, 1, 1'b0);
        run_instr(1'b0, OP_R, 0, 0, 1'b0);
        run_instr(1'b0, OP_BEQ, 0, 0, 1'b0);
        run_instr(1'b0, OP_BEQ, 0, 0, 1'b0);
        run_instr(1'b0, OP_BGTZAL, 0, 0, 1'b0);
        run_instr(1'b0, OP_BGTZAL, 0, 0, 1'b0);
        run_instr(1'b0, OP_BRNV, 0, 0, 1'b0);
        run_instr(1'b0, 6'b111111, 0, 0, 1'b0);
        run_instr(1'b0, OP_SW, 0, 2, 1'b1);
        run_instr(1'b0, OP_LW, 0, 3, 1'b1);
        for (int n = 0; n < 60; n++) begin
            run_instr(1'b0, pick_op(), $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
        end

        rst_a = 1'b1;
        rst_b = 1'b0;
        run_instr(1'b1, OP_BRNV, 0, 0, 1'b0);
        run_instr(1'b1, OP_BGTZAL, 0, 0, 1'b0);
        run_instr(1'b1, OP_LW, 2, 2, 1'b0);
        run_instr(1'b1, OP_SW, 2, 2, 1'b0);
        for (int n = 0; n < 30; n++) begin
            run_instr(1'b1, pick_op(), 0, 0, 1'b0);
        end
        @(negedge clk);
        chk("held reset outputs a", 32'(obs_a), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
